// File: rtl/next_piece_fetcher.sv
// Reads the 3x4 next-piece preview window from grid memory, decodes the piece
// type and translates the occupied preview cells into playfield spawn addresses.
module next_piece_fetcher #(
    parameter logic [7:0] NEXT_PIECE_BASE_ADDR = 8'd240,
    parameter int         GRID_WIDTH           = 10,
    parameter int         SPAWN_ROW            = 0,
    parameter int         SPAWN_COL            = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic       rd_en,
    output logic [7:0] rd_addr,
    input  logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic [2:0] piece_type,
    output logic [7:0] cell_addr_1,
    output logic [7:0] cell_addr_2,
    output logic [7:0] cell_addr_3,
    output logic [7:0] cell_addr_4,
    output logic       error,
    output logic [1:0] state_dbg
);

    // Handshake: start is a level sampled only in IDLE; once accepted, busy is
    // high until the single-cycle done pulse, and results hold until the next
    // accepted start. start seen while busy or during done is dropped.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_LAST = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0] rd_idx;
    logic [2:0] count;
    logic [7:0] first_q;
    logic [2:0] type_q;
    logic       error_q;
    logic [7:0] slot_q [4];

    logic       cap_en;
    logic [3:0] cap_k;
    logic [7:0] cap_addr;
    logic       slot_we;
    logic [2:0] cnt_nxt;
    logic [7:0] first_nxt;
    logic [2:0] type_nxt;
    logic       err_nxt;
    logic [7:0] type_tmp;

    // Row/col come from compares against multiples of 3; the multiply is by
    // elaboration constants only.
    function automatic logic [7:0] spawn_addr(input logic [3:0] k);
        int row;
        int col;
        int lin;
        if (k < 4'd3) begin
            row = 0;
            col = 32'(k);
        end else if (k < 4'd6) begin
            row = 1;
            col = 32'(k) - 3;
        end else if (k < 4'd9) begin
            row = 2;
            col = 32'(k) - 6;
        end else begin
            row = 3;
            col = 32'(k) - 9;
        end
        lin = (SPAWN_ROW + row) * GRID_WIDTH + SPAWN_COL + col;
        return lin[7:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (start) state_nxt = S_READ;
            S_READ: if (rd_idx == 4'd11) state_nxt = S_LAST;
            S_LAST: state_nxt = S_DONE;
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        rd_en     = (state == S_READ);
        rd_addr   = (state == S_READ) ? NEXT_PIECE_BASE_ADDR + {4'd0, rd_idx} : 8'd0;
        busy      = (state == S_READ) || (state == S_LAST);
        done      = (state == S_DONE);
        state_dbg = state;
    end

    // Data for the address issued one cycle earlier arrives now.
    always_comb begin
        cap_en    = ((state == S_READ) && (rd_idx != 4'd0)) || (state == S_LAST);
        cap_k     = (state == S_LAST) ? 4'd11 : rd_idx - 4'd1;
        cap_addr  = spawn_addr(cap_k);
        slot_we   = 1'b0;
        cnt_nxt   = count;
        first_nxt = first_q;
        type_nxt  = type_q;
        err_nxt   = error_q;
        type_tmp  = rd_data - 8'd1;
        if (cap_en && (rd_data != 8'd0)) begin
            if (rd_data > 8'd7) err_nxt = 1'b1;
            if (first_q == 8'd0) begin
                first_nxt = rd_data;
                type_nxt  = type_tmp[2:0];
            end else if (rd_data != first_q) begin
                err_nxt = 1'b1;
            end
            if (count < 3'd4) begin
                slot_we = 1'b1;
                cnt_nxt = count + 3'd1;
            end else begin
                err_nxt = 1'b1;
            end
        end
        if ((state == S_LAST) && (cnt_nxt != 3'd4)) err_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst || ((state == S_IDLE) && start)) begin
            rd_idx  <= 4'd0;
            count   <= 3'd0;
            first_q <= 8'd0;
            type_q  <= 3'd0;
            error_q <= 1'b0;
            for (int i = 0; i < 4; i++) slot_q[i] <= 8'd0;
        end else begin
            if (state == S_READ) rd_idx <= rd_idx + 4'd1;
            count   <= cnt_nxt;
            first_q <= first_nxt;
            type_q  <= type_nxt;
            error_q <= err_nxt;
            if (slot_we) slot_q[count[1:0]] <= cap_addr;
        end
    end

    assign piece_type  = type_q;
    assign error       = error_q;
    assign cell_addr_1 = slot_q[0];
    assign cell_addr_2 = slot_q[1];
    assign cell_addr_3 = slot_q[2];
    assign cell_addr_4 = slot_q[3];

endmodule

// File: tb/tb_next_piece_fetcher.sv
// Bench for next_piece_fetcher: directed preview patterns, reset abort, start
// filtering, back-to-back fetches and randomized previews against a model.
module tb_next_piece_fetcher;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start_a, start_b;
    logic       rd_en_a, rd_en_b;
    logic [7:0] rd_addr_a, rd_addr_b;
    logic [7:0] rd_data_a, rd_data_b;
    logic       busy_a, busy_b, done_a, done_b, error_a, error_b;
    logic [2:0] type_a, type_b;
    logic [7:0] ca1_a, ca2_a, ca3_a, ca4_a;
    logic [7:0] ca1_b, ca2_b, ca3_b, ca4_b;
    logic [1:0] dbg_a, dbg_b;

    logic [7:0] mem_a [256];
    logic [7:0] mem_b [256];

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q [$];

    next_piece_fetcher dut_a (
        .clk(clk), .rst(rst), .start(start_a),
        .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a),
        .busy(busy_a), .done(done_a), .piece_type(type_a),
        .cell_addr_1(ca1_a), .cell_addr_2(ca2_a), .cell_addr_3(ca3_a), .cell_addr_4(ca4_a),
        .error(error_a), .state_dbg(dbg_a)
    );

    next_piece_fetcher #(.SPAWN_ROW(2), .SPAWN_COL(3)) dut_b (
        .clk(clk), .rst(rst), .start(start_b),
        .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b),
        .busy(busy_b), .done(done_b), .piece_type(type_b),
        .cell_addr_1(ca1_b), .cell_addr_2(ca2_b), .cell_addr_3(ca3_b), .cell_addr_4(ca4_b),
        .error(error_b), .state_dbg(dbg_b)
    );

    // Grid memory: one-cycle read latency, always returns the addressed byte.
    always @(posedge clk) begin
        rd_data_a <= mem_a[rd_addr_a];
        rd_data_b <= mem_b[rd_addr_b];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: list occupied cells, keep the first four, and judge the preview
    // well-formed only with exactly four cells of one legal piece value.
    task automatic ref_model(input logic [7:0] c [12], input int srow, input int scol,
                             output logic [2:0] t, output logic [7:0] a [4], output logic e);
        int occ [$];
        logic [7:0] vals [$];
        logic [7:0] tmp;
        int lin;
        for (int k = 0; k < 12; k++) begin
            if (c[k] != 8'd0) begin
                occ.push_back(k);
                vals.push_back(c[k]);
            end
        end
        for (int i = 0; i < 4; i++) a[i] = 8'd0;
        t = 3'd0;
        e = (occ.size() != 4);
        if (occ.size() > 0) begin
            tmp = vals[0] - 8'd1;
            t = tmp[2:0];
        end
        foreach (vals[i]) if (vals[i] != vals[0] || vals[i] > 8'd7) e = 1'b1;
        for (int i = 0; i < 4 && i < occ.size(); i++) begin
            lin = (srow + occ[i] / 3) * 10 + scol + occ[i] % 3;
            a[i] = lin[7:0];
        end
    endtask

    task automatic load_a(input logic [7:0] c [12]);
        for (int k = 0; k < 12; k++) mem_a[240 + k] = c[k];
    endtask

    task automatic run_fetch(input string name, input logic [7:0] c [12], input bit extra_starts);
        logic [2:0] et;
        logic [7:0] ea [4];
        logic       ee;
        logic [7:0] want;
        logic [2:0] ctl_exp;
        bit         quiet;
        ref_model(c, 0, 4, et, ea, ee);
        load_a(c);
        exp_q.delete();
        for (int k = 0; k < 12; k++) exp_q.push_back(8'(240 + k));
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 1; n <= 14; n++) begin
            start_a = extra_starts && (n == 3 || n == 14);
            ctl_exp = (n <= 12) ? 3'b110 : (n == 13) ? 3'b010 : 3'b001;
            total++;
            if ({rd_en_a, busy_a, done_a} !== ctl_exp) begin
                bad++;
                $display("FAIL %s ctl cycle=%0d rd_en/busy/done got=%b exp=%b", name, n,
                         {rd_en_a, busy_a, done_a}, ctl_exp);
            end
            if (n <= 12) begin
                want = exp_q.pop_front();
                total++;
                if (rd_addr_a !== want) begin
                    bad++;
                    $display("FAIL %s rd_addr cycle=%0d got=%0d exp=%0d", name, n, rd_addr_a, want);
                end
            end
            if (n == 14) begin
                total++;
                if ({type_a, error_a, ca1_a, ca2_a, ca3_a, ca4_a} !== {et, ee, ea[0], ea[1], ea[2], ea[3]}) begin
                    bad++;
                    $display("FAIL %s result got type=%0d err=%b addrs=%0d,%0d,%0d,%0d exp type=%0d err=%b addrs=%0d,%0d,%0d,%0d",
                             name, type_a, error_a, ca1_a, ca2_a, ca3_a, ca4_a,
                             et, ee, ea[0], ea[1], ea[2], ea[3]);
                end
            end
            tick();
        end
        start_a = 1'b0;
        total++;
        if ({busy_a, done_a, type_a, error_a, ca1_a, ca4_a} !== {2'b00, et, ee, ea[0], ea[3]}) begin
            bad++;
            $display("FAIL %s hold got busy=%b done=%b type=%0d err=%b a1=%0d a4=%0d",
                     name, busy_a, done_a, type_a, error_a, ca1_a, ca4_a);
        end
        if (extra_starts) begin
            quiet = 1'b1;
            for (int i = 0; i < 20; i++) begin
                if (busy_a || done_a) quiet = 1'b0;
                tick();
            end
            total++;
            if (quiet !== 1'b1) begin
                bad++;
                $display("FAIL %s ignored_start got=restart exp=idle", name);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start_a = 1'b1;
        start_b = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        total++;
        if ({rd_en_a, rd_addr_a, busy_a, done_a, type_a, error_a, ca1_a, ca2_a, ca3_a, ca4_a} !== 49'd0) begin
            bad++;
            $display("FAIL reset outputs got en=%b addr=%0d busy=%b done=%b type=%0d err=%b exp all 0",
                     rd_en_a, rd_addr_a, busy_a, done_a, type_a, error_a);
        end
        start_a = 1'b0;
        start_b = 1'b0;
        rst = 1'b1;
        tick();
        total++;
        if ({busy_a, busy_b, rd_en_a} !== 3'b000) begin
            bad++;
            $display("FAIL reset_release busy got=%b exp=000", {busy_a, busy_b, rd_en_a});
        end
    endtask

    task automatic test_directed();
        logic [7:0] c [12];
        c = '{default: 8'd0};
        c[0] = 8'd1; c[3] = 8'd1; c[6] = 8'd1; c[9] = 8'd1;
        run_fetch("i_piece", c, 1'b0);
        total++;
        if ({type_a, error_a, ca1_a, ca2_a, ca3_a, ca4_a} !== {3'd0, 1'b0, 8'd4, 8'd14, 8'd24, 8'd34}) begin
            bad++;
            $display("FAIL i_piece_literal got type=%0d addrs=%0d,%0d,%0d,%0d exp 0 4,14,24,34",
                     type_a, ca1_a, ca2_a, ca3_a, ca4_a);
        end
        c = '{default: 8'd0};
        c[6] = 8'd5; c[7] = 8'd5; c[10] = 8'd5; c[11] = 8'd5;
        run_fetch("z_piece", c, 1'b0);
        c = '{default: 8'd0};
        c[7] = 8'd4; c[8] = 8'd4; c[9] = 8'd4; c[10] = 8'd4;
        run_fetch("s_piece", c, 1'b0);
        c = '{default: 8'd0};
        run_fetch("all_zero", c, 1'b0);
        c = '{default: 8'd0};
        for (int k = 0; k < 5; k++) c[k] = 8'd3;
        run_fetch("five_cells", c, 1'b0);
        c = '{default: 8'd0};
        c[0] = 8'd1; c[3] = 8'd1; c[6] = 8'd1; c[9] = 8'd2;
        run_fetch("mixed_values", c, 1'b0);
        c = '{default: 8'd0};
        c[1] = 8'd9; c[2] = 8'd9; c[4] = 8'd9; c[5] = 8'd9;
        run_fetch("value_gt7", c, 1'b0);
    endtask

    task automatic test_reset_mid_fetch();
        logic [7:0] c [12];
        bit quiet;
        c = '{default: 8'd0};
        c[0] = 8'd3; c[1] = 8'd3; c[2] = 8'd3; c[4] = 8'd3;
        load_a(c);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int n = 1; n < 7; n++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        total++;
        if ({rd_en_a, rd_addr_a, busy_a, done_a, type_a, error_a, ca1_a, ca2_a, ca3_a, ca4_a} !== 49'd0) begin
            bad++;
            $display("FAIL abort_outputs got en=%b addr=%0d busy=%b done=%b type=%0d err=%b a1=%0d exp all 0",
                     rd_en_a, rd_addr_a, busy_a, done_a, type_a, error_a, ca1_a);
        end
        quiet = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (done_a || busy_a) quiet = 1'b0;
            tick();
        end
        total++;
        if (quiet !== 1'b1) begin
            bad++;
            $display("FAIL abort_no_done got=activity exp=idle");
        end
        run_fetch("after_abort", c, 1'b0);
    endtask

    task automatic test_start_filter();
        logic [7:0] c [12];
        c = '{default: 8'd0};
        c[1] = 8'd6; c[4] = 8'd6; c[7] = 8'd6; c[6] = 8'd6;
        run_fetch("start_pulses", c, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] c [12];
        logic [2:0] et;
        logic [7:0] ea [4];
        logic       ee;
        int done_cyc [$];
        int waited;
        c = '{default: 8'd0};
        c[1] = 8'd3; c[3] = 8'd3; c[4] = 8'd3; c[5] = 8'd3;
        ref_model(c, 0, 4, et, ea, ee);
        load_a(c);
        start_a = 1'b1;
        tick();
        for (int n = 1; n <= 50; n++) begin
            if (done_a) begin
                done_cyc.push_back(n);
                total++;
                if ({type_a, error_a, ca1_a, ca2_a, ca3_a, ca4_a} !== {et, ee, ea[0], ea[1], ea[2], ea[3]}) begin
                    bad++;
                    $display("FAIL b2b_result cycle=%0d got type=%0d err=%b a1=%0d exp type=%0d err=%b a1=%0d",
                             n, type_a, error_a, ca1_a, et, ee, ea[0]);
                end
            end
            tick();
        end
        start_a = 1'b0;
        total++;
        if (done_cyc.size() != 3 || done_cyc[0] != 14 || done_cyc[1] != 29 || done_cyc[2] != 44) begin
            bad++;
            $display("FAIL b2b_timing got count=%0d first=%0d exp 3 at 14,29,44",
                     done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
        end
        waited = 0;
        while (!done_a && waited < 30) begin
            tick();
            waited++;
        end
        total++;
        if (waited >= 30) begin
            bad++;
            $display("FAIL b2b_drain got=no_done exp=done");
        end
        tick();
    endtask

    task automatic test_param();
        logic [2:0] et;
        logic [7:0] ea [4];
        logic       ee;
        logic [7:0] c [12];
        int n;
        c = '{default: 8'd0};
        c[6] = 8'd2; c[7] = 8'd2; c[9] = 8'd2; c[10] = 8'd2;
        for (int k = 0; k < 12; k++) mem_b[240 + k] = c[k];
        ref_model(c, 2, 3, et, ea, ee);
        start_b = 1'b1;
        tick();
        start_b = 1'b0;
        n = 1;
        while (!done_b && n < 30) begin
            tick();
            n++;
        end
        total++;
        if (n != 14) begin
            bad++;
            $display("FAIL param_latency got=%0d exp=14", n);
        end
        total++;
        if ({type_b, error_b, ca1_b, ca2_b, ca3_b, ca4_b} !== {et, ee, ea[0], ea[1], ea[2], ea[3]} ||
            {type_b, ca1_b, ca2_b, ca3_b, ca4_b} !== {3'd1, 8'd43, 8'd44, 8'd53, 8'd54}) begin
            bad++;
            $display("FAIL param_o_piece got type=%0d err=%b addrs=%0d,%0d,%0d,%0d exp 1 0 43,44,53,54",
                     type_b, error_b, ca1_b, ca2_b, ca3_b, ca4_b);
        end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] c [12];
        int pos [12];
        int j, tmp, npos;
        logic [7:0] v;
        for (int it = 0; it < 25; it++) begin
            c = '{default: 8'd0};
            for (int k = 0; k < 12; k++) pos[k] = k;
            for (int k = 11; k > 0; k--) begin
                j = $urandom_range(0, k);
                tmp = pos[k]; pos[k] = pos[j]; pos[j] = tmp;
            end
            if ($urandom_range(0, 3) != 0) begin
                v = 8'($urandom_range(1, 7));
                for (int k = 0; k < 4; k++) c[pos[k]] = v;
            end else begin
                npos = $urandom_range(0, 7);
                for (int k = 0; k < npos; k++) c[pos[k]] = 8'($urandom_range(1, 9));
            end
            run_fetch("random", c, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = 8'd0;
            mem_b[i] = 8'd0;
        end
        mem_a[0] = 8'h55;
        mem_b[0] = 8'h55;
        rst = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        #1;
        test_reset();
        test_directed();
        test_reset_mid_fetch();
        test_start_filter();
        test_back_to_back();
        test_param();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/next_piece_fetcher.md
Name: next_piece_fetcher

Overview:
- Reader for the next-piece preview region of grid memory: a 3-wide x 4-tall window of 12 cells at NEXT_PIECE_BASE_ADDR (240..251).
- On start, it reads all 12 cells in order through the grid memory read port and works out the piece type.
- It translates the four occupied preview cells into playfield spawn addresses and pulses done.
- The spawn/move logic consumes the result to load the active piece.

Parameters:
NEXT_PIECE_BASE_ADDR, 8'd240, first preview cell address; preview cell k (0..11) is at base+k, row=k/3, col=k%3
GRID_WIDTH, 10, playfield columns
SPAWN_ROW, 0, playfield row that maps to preview row 0
SPAWN_COL, 4, playfield column that maps to preview col 0

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-low (0 = reset)
start  input  1  request a fetch; sampled only in IDLE
rd_en  output  1  grid memory read enable
rd_addr  output  8  grid memory read address
rd_data  input  8  grid memory read data; 1-cycle latency
busy  output  1  high from the cycle after start is accepted until done
done  output  1  one-cycle pulse; result outputs valid from this cycle
piece_type  output  3  first nonzero cell value minus 1 (I=0,O=1,T=2,S=3,Z=4,J=5,L=6)
cell_addr_1..cell_addr_4  output  8 each  playfield addresses of occupied cells, in ascending k
error  output  1  preview malformed; valid with done

Behaviour:
- Reset (rst=0 at an edge): state IDLE; rd_en, rd_addr, busy, done, error = 0; piece_type = 0; cell_addr_1..4 = 0; internal count/slot index = 0.
- Reset mid-fetch aborts immediately with the same values. No done is produced.
- Memory timing: a value presented on rd_addr in cycle c returns on rd_data in cycle c+1. The block samples it at the end of cycle c+1.
- States: IDLE -> READ -> LAST -> DONE -> IDLE.
- IDLE:
  - start=1 at edge E0 -> READ.
  - busy=1, rd_en=1, rd_addr=base from cycle 1.
  - On entry to READ, clear the slots, count, type and error.
- READ:
  - In cycle n (n=1..12), rd_addr = base+n-1 and rd_en=1.
  - From cycle 2 on, capture rd_data for cell k=n-2.
  - After cycle 12 -> LAST, with rd_en=0.
- LAST (cycle 13): capture cell 11 -> DONE.
- DONE (cycle 14): done=1 for one cycle, busy=0 -> IDLE.
  - Result outputs hold until the next accepted start.
  - Total latency: done in cycle 14 relative to start at E0.
- Per captured cell k with value v:
  - v=0: empty, ignored.
  - v!=0 and count<4: cell_addr_{count+1} = (SPAWN_ROW+k/3)*GRID_WIDTH + SPAWN_COL + k%3, truncated to 8 bits; count increments.
  - Division is by constant 3; implement by compare or lookup, no divider.
  - The first nonzero v sets piece_type = v-1 (3 bits).
  - Any later nonzero v that differs from the first sets error.
  - v>7 sets error.
  - v!=0 with count already 4: ignored for addresses, sets error.
- At completion, count!=4 sets error; unfilled cell_addr slots stay 0.
- All-zero preview gives piece_type=0, error=1.
- start while busy is ignored: no restart, no queueing.
- start held high through DONE: a new fetch begins at the edge after done, i.e. back-to-back every 15 cycles.
- rd_data is ignored outside READ/LAST.

Test Plan:
- I piece: cells 0,3,6,9=1, others 0; start at cycle 0 -> rd_addr 240..251 in cycles 1..12; done in cycle 14; piece_type=0; addrs 4,14,24,34; error=0.
- Z piece: cells 6,7,10,11=5 -> piece_type=4; addrs 24,25,35,36; error=0. S piece: cells 7,8,9,10=4 -> piece_type=3; addrs 25,26,34,35.
- Malformed previews:
  - All 12 cells 0 -> error=1, piece_type=0, addrs all 0.
  - Five cells 0,1,2,3,4=3 -> addrs 4,5,6,14; error=1.
  - Cells 0,3,6=1 and 9=2 -> error=1.
- Reset pulled low in cycle 7 of a fetch -> next cycle all outputs 0 and IDLE; no done; a new start completes normally 14 cycles later.
- start pulsed again in cycles 3 and 14 of a fetch -> single done in cycle 14, ignored start causes no second fetch. start held high continuously -> done every 15 cycles.
- Non-default parameters SPAWN_ROW=2, SPAWN_COL=3 with the O piece (cells 6,7,9,10=2) -> addrs 43,44,53,54; piece_type=1.
